// File: rtl/key_pkg.sv
// Shared definitions for the pushbutton controller: default register
// addresses, KCTRL bit positions, key count and the bus-cycle decode type.
package key_pkg;

  localparam int unsigned NUM_KEYS = 4;

  localparam logic [31:0] DEF_DATA_ADDR = 32'hF000_0010;
  localparam logic [31:0] DEF_CTRL_ADDR = 32'hF000_0110;

  localparam int unsigned READY_BIT   = 0;
  localparam int unsigned OVERRUN_BIT = 2;
  localparam int unsigned IE_BIT      = 8;

  typedef enum logic [1:0] {
    BUS_IDLE,
    BUS_RD_DATA,
    BUS_RD_CTRL,
    BUS_WR_CTRL
  } bus_op_e;

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: 2-flop synchronizer, optional debounce counter
// (KEY_DEBOUNCE_EN) and the registered, active-high `stable` state.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic stable,
  output logic changed
);

  logic sync1;
  logic sync2;
  logic stable_next;

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
    $error("key_debounce: DEBOUNCE_CYCLES must be at least 2");
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
    end
  end

`ifdef KEY_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  // Counter only runs while the synchronized level disagrees with `stable`;
  // any agreeing sample restarts it, so glitches never accumulate.
  always_comb begin
    cnt_next    = '0;
    stable_next = stable;
    if (~sync2 != stable) begin
      if (cnt == CNT_LAST) begin
        stable_next = ~sync2;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end
`else
  always_comb begin
    stable_next = ~sync2;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable <= 1'b0;
    end else begin
      stable <= stable_next;
    end
  end

  // High in the cycle whose closing edge updates `stable`.
  assign changed = stable_next ^ stable;

endmodule

// File: rtl/key_controller.sv
// Memory-mapped pushbutton controller: KDATA/KCTRL registers on the shared
// tri-state dbus, sticky Ready/Overrun flags and a level interrupt.
// Debounce counters are built only when KEY_DEBOUNCE_EN is defined.
module key_controller
  import key_pkg::*;
#(
  parameter int unsigned       DBITS           = 32,
  parameter logic [DBITS-1:0]  DATA_ADDR       = DBITS'(DEF_DATA_ADDR),
  parameter logic [DBITS-1:0]  CTRL_ADDR       = DBITS'(DEF_CTRL_ADDR),
  parameter int unsigned       DEBOUNCE_CYCLES = 500000
) (
  input  logic                clk,
  input  logic                reset,
  inout  wire  [DBITS-1:0]    dbus,
  input  logic [DBITS-1:0]    address,
  input  logic                wrtEn,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic                intr
);

  bus_op_e             op;
  logic [NUM_KEYS-1:0] stable;
  logic [NUM_KEYS-1:0] changed;
  logic                change_evt;
  logic                ready;
  logic                overrun;
  logic                ie;
  logic [DBITS-1:0]    kdata;
  logic [DBITS-1:0]    kctrl;
  logic [DBITS-1:0]    rd_val;
  logic                rd_en;
  logic                unused_dbus;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .key    (KEY[i]),
      .stable (stable[i]),
      .changed(changed[i])
    );
  end

  assign change_evt = |changed;

  always_comb begin
    op = BUS_IDLE;
    if ((address == DATA_ADDR) && !wrtEn) begin
      op = BUS_RD_DATA;
    end else if (address == CTRL_ADDR) begin
      op = wrtEn ? BUS_WR_CTRL : BUS_RD_CTRL;
    end
  end

  // Set conditions are tested first so a coincident read/clear never wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready   <= 1'b0;
      overrun <= 1'b0;
      ie      <= 1'b0;
    end else begin
      if (change_evt) begin
        ready <= 1'b1;
      end else if (op == BUS_RD_DATA) begin
        ready <= 1'b0;
      end

      if (change_evt && ready && (op != BUS_RD_DATA)) begin
        overrun <= 1'b1;
      end else if ((op == BUS_WR_CTRL) && !dbus[OVERRUN_BIT]) begin
        overrun <= 1'b0;
      end

      if (op == BUS_WR_CTRL) begin
        ie <= dbus[IE_BIT];
      end
    end
  end

  always_comb begin
    kdata                 = '0;
    kdata[NUM_KEYS-1:0]   = stable;
    kctrl                 = '0;
    kctrl[READY_BIT]      = ready;
    kctrl[OVERRUN_BIT]    = overrun;
    kctrl[IE_BIT]         = ie;
  end

  assign rd_val = (op == BUS_RD_CTRL) ? kctrl : kdata;
  assign rd_en  = (op == BUS_RD_DATA) || (op == BUS_RD_CTRL);
  assign dbus   = rd_en ? rd_val : 'z;

  assign intr = ready & ie;

  assign unused_dbus = ^dbus;

endmodule
